// File: rtl/ahb_decoder_mux.sv
// AHB address decoder and response multiplexer with a built-in default slave that
// answers unmapped active transfers with a two-cycle ERROR and counts them.
module ahb_decoder_mux #(
  parameter int unsigned SLAVE_NUMBER = 11,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter logic [SLAVE_NUMBER*ADDR_W-1:0] SLAVE_LOW_ADDR = {
    32'd318, 32'd286, 32'd254, 32'd222, 32'd190, 32'd158,
    32'd126, 32'd94,  32'd63,  32'd32,  32'd0},
  parameter logic [SLAVE_NUMBER*ADDR_W-1:0] SLAVE_HIGH_ADDR = {
    32'd349, 32'd317, 32'd285, 32'd253, 32'd221, 32'd189,
    32'd157, 32'd125, 32'd93,  32'd62,  32'd31},
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [ADDR_W-1:0]              HADDR,
  input  logic [1:0]                     HTRANS,
  output logic [SLAVE_NUMBER-1:0]        HSEL,
  input  logic [SLAVE_NUMBER-1:0]        HREADYOUT_S,
  input  logic [2*SLAVE_NUMBER-1:0]      HRESP_S,
  input  logic [DATA_W*SLAVE_NUMBER-1:0] HRDATA_S,
  output logic                           HREADY,
  output logic [1:0]                     HRESP,
  output logic [DATA_W-1:0]              HRDATA,
  output logic [ERR_CNT_W-1:0]           ERR_COUNT
);

  localparam logic [1:0] RespOkay  = 2'd0;
  localparam logic [1:0] RespError = 2'd1;

  typedef enum logic [1:0] {DsIdle, DsErr1, DsErr2} ds_state_e;

  ds_state_e               ds_state_q, ds_state_d;
  logic [SLAVE_NUMBER-1:0] dp_sel_q;
  logic                    dp_def_q;
  logic                    dp_active_q;
  logic [ERR_CNT_W-1:0]    err_count_q;
  logic                    hit_any;
  logic                    active_miss;

  // Lowest-index match wins so HSEL stays one-hot even with overlapping ranges.
  always_comb begin
    HSEL    = '0;
    hit_any = 1'b0;
    for (int unsigned i = 0; i < SLAVE_NUMBER; i++) begin
      if (!hit_any &&
          HADDR >= SLAVE_LOW_ADDR[i*ADDR_W +: ADDR_W] &&
          HADDR <= SLAVE_HIGH_ADDR[i*ADDR_W +: ADDR_W]) begin
        HSEL[i] = 1'b1;
        hit_any = 1'b1;
      end
    end
  end

  assign active_miss = HTRANS[1] && !hit_any;

  always_comb begin
    HREADY = 1'b1;
    HRESP  = RespOkay;
    HRDATA = '0;
    for (int unsigned i = 0; i < SLAVE_NUMBER; i++) begin
      if (dp_sel_q[i]) begin
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[2*i +: 2];
        HRDATA = HRDATA_S[DATA_W*i +: DATA_W];
      end
    end
    if (dp_def_q && dp_active_q) begin
      unique case (ds_state_q)
        DsErr1: begin
          HREADY = 1'b0;
          HRESP  = RespError;
        end
        DsErr2: begin
          HREADY = 1'b1;
          HRESP  = RespError;
        end
        default: ;
      endcase
    end
  end

  // A new active miss can only be accepted while HREADY is high (IDLE or ERR2).
  always_comb begin
    ds_state_d = DsIdle;
    if (HREADY && active_miss) begin
      ds_state_d = DsErr1;
    end else if (ds_state_q == DsErr1) begin
      ds_state_d = DsErr2;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ds_state_q  <= DsIdle;
      dp_sel_q    <= '0;
      dp_def_q    <= 1'b1;
      dp_active_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      ds_state_q <= ds_state_d;
      if (HREADY) begin
        dp_sel_q    <= HSEL;
        dp_def_q    <= !hit_any;
        dp_active_q <= HTRANS[1];
      end
      if (ds_state_d == DsErr1 && err_count_q != '1) begin
        err_count_q <= err_count_q + ERR_CNT_W'(1);
      end
    end
  end

  assign ERR_COUNT = err_count_q;

endmodule
